// File: rtl/fifo_param.sv
// fifo_param -- parametrised single-clock FIFO with selectable read latency.
//
// Purpose:
//   Buffers WIDTH-bit words between a producer and a consumer that share
//   CLOCK. Storage is an internal DEPTH x WIDTH register array. Read latency
//   is either one cycle (registered DATA_OUT, SHOW_AHEAD = 0) or zero cycles
//   (first-word fall-through, SHOW_AHEAD = 1).
//
// Parameters:
//   WIDTH      data word width (>= 1)
//   DEPTH      number of words, power of two, >= 4
//   AFULL_TH   almost-full threshold, 1 .. DEPTH
//   AEMPTY_TH  almost-empty threshold, 0 .. DEPTH-1
//   SHOW_AHEAD 0 = registered read, 1 = first-word fall-through
//
// Ports:
//   CLOCK       in   system clock, rising edge
//   RESET_N     in   asynchronous active-low reset
//   CLEAR_N     in   synchronous active-low clear (same effect as reset)
//   WRITE       in   write request
//   READ        in   read request
//   DATA_IN     in   write data
//   DATA_OUT    out  read data
//   F_FULL_N    out  low when USE_DW == DEPTH
//   F_EMPTY_N   out  low when USE_DW == 0
//   F_AFULL_N   out  low when USE_DW >= AFULL_TH
//   F_AEMPTY_N  out  low when USE_DW <= AEMPTY_TH
//   USE_DW      out  stored word count, 0 .. DEPTH
//   OVF_ERR     out  one-cycle pulse, a write was rejected
//   UDF_ERR     out  one-cycle pulse, a read was rejected

module fifo_param #(
  parameter int WIDTH      = 8,
  parameter int DEPTH      = 32,
  parameter int AFULL_TH   = DEPTH - 4,
  parameter int AEMPTY_TH  = 4,
  parameter int SHOW_AHEAD = 0
) (
  input  logic                       CLOCK,
  input  logic                       RESET_N,
  input  logic                       CLEAR_N,
  input  logic                       WRITE,
  input  logic                       READ,
  input  logic [WIDTH-1:0]           DATA_IN,
  output logic [WIDTH-1:0]           DATA_OUT,
  output logic                       F_FULL_N,
  output logic                       F_EMPTY_N,
  output logic                       F_AFULL_N,
  output logic                       F_AEMPTY_N,
  output logic [$clog2(DEPTH):0]     USE_DW,
  output logic                       OVF_ERR,
  output logic                       UDF_ERR
);

  localparam int AW = $clog2(DEPTH);

  localparam logic [AW:0]   DEPTH_C     = (AW+1)'(DEPTH);
  localparam logic [AW:0]   AFULL_C     = (AW+1)'(AFULL_TH);
  localparam logic [AW:0]   AEMPTY_C    = (AW+1)'(AEMPTY_TH);
  localparam logic [AW:0]   CNT_ONE     = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE     = AW'(1);
  // Almost-full is only asserted at count 0 if the threshold were 0 or less.
  localparam logic          AFULL_N_RST = (AFULL_TH <= 0) ? 1'b0 : 1'b1;

  // Control state mirrors the occupancy extremes; full/empty decisions for
  // accepting requests are taken from it.
  typedef enum logic [1:0] {
    S_EMPTY,
    S_PARTIAL,
    S_FULL
  } state_t;

  state_t            state_reg, state_next;
  logic [AW-1:0]     wptr_reg, wptr_next;
  logic [AW-1:0]     rptr_reg, rptr_next;
  logic [AW:0]       count_reg, count_next;
  logic              afull_n_reg, afull_n_next;
  logic              aempty_n_reg, aempty_n_next;
  logic              ovf_reg, ovf_next;
  logic              udf_reg, udf_next;
  logic              wr_ok, rd_ok;

  logic [WIDTH-1:0]  mem [DEPTH];

  // Next-state, acceptance and flag logic.
  always_comb begin
    state_next    = state_reg;
    wptr_next     = wptr_reg;
    rptr_next     = rptr_reg;
    count_next    = count_reg;
    afull_n_next  = afull_n_reg;
    aempty_n_next = aempty_n_reg;
    ovf_next      = 1'b0;
    udf_next      = 1'b0;
    wr_ok         = 1'b0;
    rd_ok         = 1'b0;

    if (!CLEAR_N) begin
      // Clear overrides both requests; storage is left as is.
      state_next    = S_EMPTY;
      wptr_next     = '0;
      rptr_next     = '0;
      count_next    = '0;
      afull_n_next  = AFULL_N_RST;
      aempty_n_next = 1'b0;
    end else begin
      rd_ok = READ && (state_reg != S_EMPTY);
      // A write into a full FIFO is fine when a read frees a slot on the
      // same edge. No pass-through when empty: the read is rejected.
      wr_ok = WRITE && ((state_reg != S_FULL) || READ);

      ovf_next = WRITE && !wr_ok;
      udf_next = READ && !rd_ok;

      if (wr_ok) wptr_next = wptr_reg + PTR_ONE;
      if (rd_ok) rptr_next = rptr_reg + PTR_ONE;

      case ({wr_ok, rd_ok})
        2'b10:   count_next = count_reg + CNT_ONE;
        2'b01:   count_next = count_reg - CNT_ONE;
        default: count_next = count_reg;
      endcase

      afull_n_next  = !(count_next >= AFULL_C);
      aempty_n_next = !(count_next <= AEMPTY_C);

      case (state_reg)
        S_EMPTY: begin
          if (wr_ok) state_next = S_PARTIAL;
        end
        S_PARTIAL: begin
          if (count_next == DEPTH_C)  state_next = S_FULL;
          else if (count_next == '0)  state_next = S_EMPTY;
        end
        S_FULL: begin
          if (rd_ok && !wr_ok) state_next = S_PARTIAL;
        end
        default: state_next = S_EMPTY;
      endcase
    end
  end

  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_reg    <= S_EMPTY;
      wptr_reg     <= '0;
      rptr_reg     <= '0;
      count_reg    <= '0;
      afull_n_reg  <= AFULL_N_RST;
      aempty_n_reg <= 1'b0;
      ovf_reg      <= 1'b0;
      udf_reg      <= 1'b0;
    end else begin
      state_reg    <= state_next;
      wptr_reg     <= wptr_next;
      rptr_reg     <= rptr_next;
      count_reg    <= count_next;
      afull_n_reg  <= afull_n_next;
      aempty_n_reg <= aempty_n_next;
      ovf_reg      <= ovf_next;
      udf_reg      <= udf_next;
    end
  end

  // Storage array carries no reset so it maps onto plain memory.
  always_ff @(posedge CLOCK) begin
    if (wr_ok) mem[wptr_reg] <= DATA_IN;
  end

  generate
    if (SHOW_AHEAD != 0) begin : g_show_ahead
      // Head word is presented combinationally; zero while empty so stale or
      // never-written storage is not exposed.
      assign DATA_OUT = (state_reg == S_EMPTY) ? '0 : mem[rptr_reg];
    end else begin : g_normal
      logic [WIDTH-1:0] dout_reg;

      // Holds the last word read; deliberately not cleared on going empty.
      always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N)     dout_reg <= '0;
        else if (!CLEAR_N) dout_reg <= '0;
        else if (rd_ok)    dout_reg <= mem[rptr_reg];
      end

      assign DATA_OUT = dout_reg;
    end
  endgenerate

  assign F_FULL_N   = (state_reg != S_FULL);
  assign F_EMPTY_N  = (state_reg != S_EMPTY);
  assign F_AFULL_N  = afull_n_reg;
  assign F_AEMPTY_N = aempty_n_reg;
  assign USE_DW     = count_reg;
  assign OVF_ERR    = ovf_reg;
  assign UDF_ERR    = udf_reg;

endmodule

// File: tb/tb_fifo_param.sv
// tb_fifo_param -- directed self-checking bench for fifo_param.
// Instance dut_n uses the default configuration (normal read, 8x32);
// instance dut_s is the show-ahead variant. Inputs change 1 time unit after
// the rising edge and outputs are checked at that same point.

module tb_fifo_param;

  logic       clk;
  logic       rst_n;

  logic       clr_n, wr, rd;
  logic [7:0] din, dout;
  logic       full_n, empty_n, afull_n, aempty_n, ovf, udf;
  logic [5:0] use_dw;

  logic       clr2_n, wr2, rd2;
  logic [7:0] din2, dout2;
  logic       full2_n, empty2_n, afull2_n, aempty2_n, ovf2, udf2;
  logic [5:0] use2;

  int tests;
  int fails;

  fifo_param #(.WIDTH(8), .DEPTH(32), .AFULL_TH(28), .AEMPTY_TH(4), .SHOW_AHEAD(0)) dut_n (
    .CLOCK(clk), .RESET_N(rst_n), .CLEAR_N(clr_n), .WRITE(wr), .READ(rd),
    .DATA_IN(din), .DATA_OUT(dout), .F_FULL_N(full_n), .F_EMPTY_N(empty_n),
    .F_AFULL_N(afull_n), .F_AEMPTY_N(aempty_n), .USE_DW(use_dw),
    .OVF_ERR(ovf), .UDF_ERR(udf)
  );

  fifo_param #(.WIDTH(8), .DEPTH(32), .AFULL_TH(28), .AEMPTY_TH(4), .SHOW_AHEAD(1)) dut_s (
    .CLOCK(clk), .RESET_N(rst_n), .CLEAR_N(clr2_n), .WRITE(wr2), .READ(rd2),
    .DATA_IN(din2), .DATA_OUT(dout2), .F_FULL_N(full2_n), .F_EMPTY_N(empty2_n),
    .F_AFULL_N(afull2_n), .F_AEMPTY_N(aempty2_n), .USE_DW(use2),
    .OVF_ERR(ovf2), .UDF_ERR(udf2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Flag vector order: {F_FULL_N, F_EMPTY_N, F_AFULL_N, F_AEMPTY_N, OVF_ERR, UDF_ERR}
  task automatic test_reset();
    rst_n = 1'b0; clr_n = 1'b1; wr = 1'b0; rd = 1'b0; din = 8'h00;
    clr2_n = 1'b1; wr2 = 1'b0; rd2 = 1'b0; din2 = 8'h00;
    repeat (2) step();
    tests++;
    if ({full_n, empty_n, afull_n, aempty_n, ovf, udf} !== 6'b101000) begin
      fails++; $display("FAIL reset_flags: got %b expected 101000", {full_n, empty_n, afull_n, aempty_n, ovf, udf});
    end
    tests++;
    if ({use_dw, dout} !== 14'h0) begin
      fails++; $display("FAIL reset_count_data: USE_DW=%0d DATA_OUT=%h expected 0/00", use_dw, dout);
    end
    tests++;
    if ({use2, dout2, empty2_n} !== 15'h0) begin
      fails++; $display("FAIL reset_sa: USE_DW=%0d DATA_OUT=%h F_EMPTY_N=%b expected 0/00/0", use2, dout2, empty2_n);
    end
    rst_n = 1'b1;
    step();
    $display("[TB] reset released, USE_DW=%0d", use_dw);
  endtask

  task automatic test_fill();
    logic [5:0] exp_f;
    for (int k = 1; k <= 32; k++) begin
      wr = 1'b1; din = 8'(k);
      step();
      exp_f = {(k != 32), 1'b1, (k < 28), (k > 4), 2'b00};
      tests++;
      if (use_dw !== 6'(k) || {full_n, empty_n, afull_n, aempty_n, ovf, udf} !== exp_f) begin
        fails++;
        $display("FAIL fill_%0d: USE_DW=%0d flags=%b expected %0d/%b", k, use_dw,
                 {full_n, empty_n, afull_n, aempty_n, ovf, udf}, k, exp_f);
      end
    end
    wr = 1'b0;
    $display("[TB] fill done, USE_DW=%0d", use_dw);
  endtask

  task automatic test_overflow();
    wr = 1'b1; din = 8'hEE;
    step();
    wr = 1'b0;
    tests++;
    if (use_dw !== 6'd32 || {full_n, empty_n, afull_n, aempty_n, ovf, udf} !== 6'b010110) begin
      fails++; $display("FAIL overflow_pulse: USE_DW=%0d flags=%b expected 32/010110", use_dw,
                        {full_n, empty_n, afull_n, aempty_n, ovf, udf});
    end
    step();
    tests++;
    if (ovf !== 1'b0 || use_dw !== 6'd32) begin
      fails++; $display("FAIL overflow_one_cycle: OVF_ERR=%b USE_DW=%0d expected 0/32", ovf, use_dw);
    end
    $display("[TB] overflow checked");
  endtask

  task automatic test_drain();
    for (int k = 1; k <= 32; k++) begin
      rd = 1'b1;
      step();
      tests++;
      if (dout !== 8'(k) || use_dw !== 6'(32 - k)) begin
        fails++; $display("FAIL drain_%0d: DATA_OUT=%h USE_DW=%0d expected %h/%0d", k, dout, use_dw, 8'(k), 32 - k);
      end
    end
    rd = 1'b0;
    tests++;
    if ({full_n, empty_n, afull_n, aempty_n, ovf, udf} !== 6'b101000) begin
      fails++; $display("FAIL drain_empty_flags: got %b expected 101000", {full_n, empty_n, afull_n, aempty_n, ovf, udf});
    end
    $display("[TB] drain done, DATA_OUT=%h", dout);
  endtask

  task automatic test_underflow();
    rd = 1'b1;
    step();
    rd = 1'b0;
    tests++;
    if (udf !== 1'b1 || use_dw !== 6'd0 || dout !== 8'h20) begin
      fails++; $display("FAIL underflow_pulse: UDF_ERR=%b USE_DW=%0d DATA_OUT=%h expected 1/0/20", udf, use_dw, dout);
    end
    step();
    tests++;
    if (udf !== 1'b0) begin
      fails++; $display("FAIL underflow_one_cycle: UDF_ERR=%b expected 0", udf);
    end
    $display("[TB] underflow checked");
  endtask

  task automatic test_simultaneous();
    // Empty: only the write is taken.
    wr = 1'b1; rd = 1'b1; din = 8'h55;
    step();
    wr = 1'b0;
    tests++;
    if (use_dw !== 6'd1 || udf !== 1'b1 || ovf !== 1'b0) begin
      fails++; $display("FAIL simul_empty: USE_DW=%0d UDF_ERR=%b OVF_ERR=%b expected 1/1/0", use_dw, udf, ovf);
    end
    step();
    rd = 1'b0;
    tests++;
    if (dout !== 8'h55 || use_dw !== 6'd0) begin
      fails++; $display("FAIL simul_empty_read: DATA_OUT=%h USE_DW=%0d expected 55/0", dout, use_dw);
    end
    // Full: both taken, count stays at DEPTH.
    for (int k = 0; k < 32; k++) begin
      wr = 1'b1; din = 8'h80 + 8'(k);
      step();
    end
    wr = 1'b1; rd = 1'b1; din = 8'hAA;
    step();
    wr = 1'b0; rd = 1'b0;
    tests++;
    if (use_dw !== 6'd32 || dout !== 8'h80 || ovf !== 1'b0 || full_n !== 1'b0) begin
      fails++; $display("FAIL simul_full: USE_DW=%0d DATA_OUT=%h OVF_ERR=%b F_FULL_N=%b expected 32/80/0/0",
                        use_dw, dout, ovf, full_n);
    end
    $display("[TB] simultaneous checked");
  endtask

  task automatic test_reset_mid();
    #3;
    rst_n = 1'b0;
    #1;
    tests++;
    if ({use_dw, dout} !== 14'h0 || {full_n, empty_n, afull_n, aempty_n, ovf, udf} !== 6'b101000) begin
      fails++; $display("FAIL reset_mid: USE_DW=%0d DATA_OUT=%h flags=%b expected 0/00/101000", use_dw, dout,
                        {full_n, empty_n, afull_n, aempty_n, ovf, udf});
    end
    #2;
    rst_n = 1'b1;
    wr = 1'b1; din = 8'h12;
    step();
    wr = 1'b0; rd = 1'b1;
    tests++;
    if (use_dw !== 6'd1 || empty_n !== 1'b1) begin
      fails++; $display("FAIL reset_mid_write: USE_DW=%0d F_EMPTY_N=%b expected 1/1", use_dw, empty_n);
    end
    step();
    rd = 1'b0;
    tests++;
    if (dout !== 8'h12 || use_dw !== 6'd0) begin
      fails++; $display("FAIL reset_mid_read: DATA_OUT=%h USE_DW=%0d expected 12/0", dout, use_dw);
    end
    $display("[TB] mid-stream reset checked");
  endtask

  task automatic test_clear();
    for (int k = 0; k < 10; k++) begin
      wr = 1'b1; din = 8'h40 + 8'(k);
      step();
    end
    tests++;
    if (use_dw !== 6'd10) begin
      fails++; $display("FAIL clear_prefill: USE_DW=%0d expected 10", use_dw);
    end
    clr_n = 1'b0; wr = 1'b1; din = 8'h99;
    step();
    clr_n = 1'b1; wr = 1'b0;
    tests++;
    if ({use_dw, dout} !== 14'h0 || {full_n, empty_n, afull_n, aempty_n, ovf, udf} !== 6'b101000) begin
      fails++; $display("FAIL clear_state: USE_DW=%0d DATA_OUT=%h flags=%b expected 0/00/101000", use_dw, dout,
                        {full_n, empty_n, afull_n, aempty_n, ovf, udf});
    end
    step();
    tests++;
    if (use_dw !== 6'd0) begin
      fails++; $display("FAIL clear_write_ignored: USE_DW=%0d expected 0", use_dw);
    end
    wr = 1'b1; din = 8'h77;
    step();
    wr = 1'b0; rd = 1'b1;
    step();
    rd = 1'b0;
    tests++;
    if (dout !== 8'h77 || use_dw !== 6'd0) begin
      fails++; $display("FAIL clear_then_rw: DATA_OUT=%h USE_DW=%0d expected 77/0", dout, use_dw);
    end
    $display("[TB] clear checked");
  endtask

  task automatic test_random();
    logic [7:0] q[$];
    logic [7:0] exp_dout;
    logic       w, r, full_m, empty_m, exp_ovf, exp_udf;
    logic [7:0] d;
    exp_dout = 8'h77;
    for (int i = 0; i < 200; i++) begin
      // First half write-heavy to reach full, second half read-heavy to drain.
      if (i < 100) begin
        w = ($urandom_range(0, 3) != 0); r = ($urandom_range(0, 3) == 0);
      end else begin
        w = ($urandom_range(0, 3) == 0); r = ($urandom_range(0, 3) != 0);
      end
      d = 8'($urandom);
      full_m  = (q.size() == 32);
      empty_m = (q.size() == 0);
      exp_ovf = w && full_m && !r;
      exp_udf = r && empty_m;
      if (r && !empty_m) exp_dout = q.pop_front();
      if (w && (!full_m || r)) q.push_back(d);
      wr = w; rd = r; din = d;
      step();
      tests++;
      if (use_dw !== 6'(q.size()) || dout !== exp_dout || ovf !== exp_ovf || udf !== exp_udf ||
          full_n !== (q.size() != 32) || empty_n !== (q.size() != 0)) begin
        fails++;
        $display("FAIL random_%0d: USE_DW=%0d DATA_OUT=%h OVF=%b UDF=%b FULL_N=%b EMPTY_N=%b expected %0d/%h/%b/%b/%b/%b",
                 i, use_dw, dout, ovf, udf, full_n, empty_n, q.size(), exp_dout, exp_ovf, exp_udf,
                 (q.size() != 32), (q.size() != 0));
      end
    end
    wr = 1'b0; rd = 1'b0;
    $display("[TB] random done, final USE_DW=%0d", use_dw);
  endtask

  task automatic test_show_ahead();
    wr2 = 1'b1; din2 = 8'h3C;
    step();
    wr2 = 1'b0; rd2 = 1'b1;
    tests++;
    if (dout2 !== 8'h3C || empty2_n !== 1'b1 || use2 !== 6'd1) begin
      fails++; $display("FAIL sa_write: DATA_OUT=%h F_EMPTY_N=%b USE_DW=%0d expected 3C/1/1", dout2, empty2_n, use2);
    end
    step();
    rd2 = 1'b0;
    tests++;
    if (dout2 !== 8'h00 || empty2_n !== 1'b0 || use2 !== 6'd0) begin
      fails++; $display("FAIL sa_read: DATA_OUT=%h F_EMPTY_N=%b USE_DW=%0d expected 00/0/0", dout2, empty2_n, use2);
    end
    wr2 = 1'b1; din2 = 8'h11;
    step();
    tests++;
    if (dout2 !== 8'h11) begin
      fails++; $display("FAIL sa_b2b_first: DATA_OUT=%h expected 11", dout2);
    end
    wr2 = 1'b1; rd2 = 1'b1; din2 = 8'h22;
    step();
    wr2 = 1'b0;
    tests++;
    if (dout2 !== 8'h22 || use2 !== 6'd1) begin
      fails++; $display("FAIL sa_b2b_second: DATA_OUT=%h USE_DW=%0d expected 22/1", dout2, use2);
    end
    step();
    rd2 = 1'b0;
    tests++;
    if (dout2 !== 8'h00 || empty2_n !== 1'b0) begin
      fails++; $display("FAIL sa_b2b_drain: DATA_OUT=%h F_EMPTY_N=%b expected 00/0", dout2, empty2_n);
    end
    $display("[TB] show-ahead checked");
  endtask

  initial begin
    tests = 0;
    fails = 0;
    test_reset();
    test_fill();
    test_overflow();
    test_drain();
    test_underflow();
    test_simultaneous();
    test_reset_mid();
    test_clear();
    test_random();
    test_show_ahead();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
